// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one 4-bit secure ALU among NUM_REQ requesters.
// Define ALU_ARB_TIMEOUT_EN to add a WAIT-state watchdog that returns an error response.
module alu_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*4-1:0] req_a,
    input  logic [NUM_REQ*4-1:0] req_b,
    input  logic [NUM_REQ*2-1:0] req_op,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [3:0]           rsp_result,
    output logic [2:0]           rsp_flags,
    output logic                 rsp_err,
    output logic                 alu_start,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [1:0]           alu_op,
    input  logic                 alu_done,
    input  logic [3:0]           alu_result,
    input  logic                 alu_carry,
    input  logic                 alu_zero,
    input  logic                 alu_overflow,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy
);

    // Handshake: a request transfers in the cycle where req_valid[i] and
    // req_ready[i] are both high; ready is only offered while IDLE, so the
    // ALU operands never change while an operation is in flight.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ID_W-1:0]   r_last_grant;
    logic [ID_W-1:0]   r_grant_id;
    logic [ID_W-1:0]   w_win_id;
    logic              w_win_any;
    logic              w_handshake;
    logic              w_timeout;
    logic [3:0]        r_alu_a;
    logic [3:0]        r_alu_b;
    logic [1:0]        r_alu_op;
    logic [3:0]        r_rsp_result;
    logic [2:0]        r_rsp_flags;
    logic              r_rsp_err;

    // Search starts one past the previous winner so every pending requester
    // is served before anyone gets a second turn.
    always_comb begin
        w_win_any = 1'b0;
        w_win_id  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_win_any && req_valid[(int'(r_last_grant) + k) % NUM_REQ]) begin
                w_win_any = 1'b1;
                w_win_id  = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
            end
        end
    end

    assign w_handshake = (r_state == S_IDLE) && w_win_any;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Fires in the TIMEOUT_CYCLES-th WAIT cycle; a done in that cycle wins.
    assign w_timeout = (r_state == S_WAIT) && !alu_done &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout            = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        alu_start    = 1'b0;
        busy         = 1'b1;
        req_ready    = '0;
        rsp_valid    = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_handshake) begin
                    req_ready[w_win_id] = 1'b1;
                    w_next_state        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_start    = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (alu_done || w_timeout) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[r_grant_id] = 1'b1;
                w_next_state          = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_grant_id   <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_alu_a    <= req_a[4*w_win_id +: 4];
                r_alu_b    <= req_b[4*w_win_id +: 4];
                r_alu_op   <= req_op[2*w_win_id +: 2];
                r_grant_id <= w_win_id;
            end
            if (r_state == S_WAIT) begin
                if (alu_done) begin
                    r_rsp_result <= alu_result;
                    r_rsp_flags  <= {alu_carry, alu_zero, alu_overflow};
                    r_rsp_err    <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_result <= '0;
                    r_rsp_flags  <= '0;
                    r_rsp_err    <= 1'b1;
                end
            end
            if (r_state == S_RESP) begin
                r_last_grant <= r_grant_id;
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign grant_id   = r_grant_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a simple latency-programmable ALU responder.
module tb_alu_req_arbiter;
    localparam int NUM_REQ        = 4;
    localparam int ID_W           = 2;
    localparam int TIMEOUT_CYCLES = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*4-1:0] req_a;
    logic [NUM_REQ*4-1:0] req_b;
    logic [NUM_REQ*2-1:0] req_op;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [3:0]           rsp_result;
    logic [2:0]           rsp_flags;
    logic                 rsp_err;
    logic                 alu_start;
    logic [3:0]           alu_a;
    logic [3:0]           alu_b;
    logic [1:0]           alu_op;
    logic                 alu_done;
    logic [3:0]           alu_result;
    logic                 alu_carry;
    logic                 alu_zero;
    logic                 alu_overflow;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc;

    // ALU responder: done arrives alu_lat cycles after the start cycle.
    int         alu_lat    = 2;
    logic       alu_en     = 1'b1;
    logic       stray_done = 1'b0;
    int         alu_cnt    = 0;
    logic [3:0] env_res    = 4'h0;
    logic [2:0] env_flags  = 3'b000;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (alu_start && alu_en) alu_cnt <= alu_lat;
        else if (alu_cnt > 0)    alu_cnt <= alu_cnt - 1;
    end

    assign alu_done     = (alu_cnt == 1) || stray_done;
    assign alu_result   = alu_done ? env_res : 4'h0;
    assign alu_carry    = alu_done ? env_flags[2] : 1'b0;
    assign alu_zero     = alu_done ? env_flags[1] : 1'b0;
    assign alu_overflow = alu_done ? env_flags[0] : 1'b0;

    alu_req_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W(ID_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_op(req_op),
        .rsp_valid(rsp_valid),
        .rsp_result(rsp_result),
        .rsp_flags(rsp_flags),
        .rsp_err(rsp_err),
        .alu_start(alu_start),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_op(alu_op),
        .alu_done(alu_done),
        .alu_result(alu_result),
        .alu_carry(alu_carry),
        .alu_zero(alu_zero),
        .alu_overflow(alu_overflow),
        .grant_id(grant_id),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (req_ready == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_rsp(input int budget, output int n);
        n = 0;
        while (rsp_valid == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_start", alu_start, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ready", req_ready, 0);
        check("rst_grant", grant_id, 0);
        check("rst_alu_ab", {alu_a, alu_b, alu_op}, 0);
        check("rst_rsp_data", {rsp_err, rsp_flags, rsp_result}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Requester 0: 3 + 5, L=2 -> result 8, flags 000
        req_valid    = 4'b0001;
        req_a[3:0]   = 4'd3;
        req_b[3:0]   = 4'd5;
        req_op[1:0]  = 2'b00;
        alu_lat      = 2;
        env_res      = 4'd8;
        env_flags    = 3'b000;
        #1;
        check("t1_ready_T", req_ready, 4'b0001);
        check("t1_busy_T", busy, 0);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("t1_start_T1", alu_start, 1);
        check("t1_alu_a", alu_a, 3);
        check("t1_alu_b", alu_b, 5);
        check("t1_alu_op", alu_op, 0);
        check("t1_grant", grant_id, 0);
        check("t1_ready_T1", req_ready, 0);
        @(negedge clk);
        check("t1_start_T2", alu_start, 0);
        check("t1_rsp_T2", rsp_valid, 0);
        @(negedge clk);
        check("t1_rsp_T3", rsp_valid, 0);
        check("t1_busy_T3", busy, 1);
        @(negedge clk);
        check("t1_rsp_T4", rsp_valid, 4'b0001);
        check("t1_result", rsp_result, 8);
        check("t1_flags", rsp_flags, 3'b000);
        check("t1_err", rsp_err, 0);
        check("t1_ready_in_resp", req_ready, 0);
        @(negedge clk);
        check("t1_rsp_T5", rsp_valid, 0);
        check("t1_busy_T5", busy, 0);
        check("t1_result_hold", rsp_result, 8);

        // Requester 1: op 01, L=3, ALU reports F with flags 100
        req_valid   = 4'b0010;
        req_a[7:4]  = 4'd2;
        req_b[7:4]  = 4'd3;
        req_op[3:2] = 2'b01;
        alu_lat     = 3;
        env_res     = 4'hF;
        env_flags   = 3'b100;
        #1;
        check("t2_ready", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("t2_alu_a", alu_a, 2);
        check("t2_alu_b", alu_b, 3);
        check("t2_alu_op", alu_op, 1);
        check("t2_grant", grant_id, 1);
        wait_rsp(20, cyc);
        check("t2_latency", cyc, 4);
        check("t2_rsp", rsp_valid, 4'b0010);
        check("t2_result", rsp_result, 4'hF);
        check("t2_flags", rsp_flags, 3'b100);

        // Stray alu_done while idle
        @(negedge clk);
        stray_done = 1'b1;
        #1;
        check("stray_busy", busy, 0);
        @(negedge clk);
        stray_done = 1'b0;
        #1;
        check("stray_busy_after", busy, 0);
        check("stray_rsp_after", rsp_valid, 0);
        check("stray_result_hold", rsp_result, 4'hF);

        // Operand change during WAIT, then reset mid-operation
        req_valid    = 4'b0100;
        req_a[11:8]  = 4'd7;
        alu_lat      = 10;
        #1;
        check("t3_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid   = '0;
        req_a[11:8] = 4'hA;
        #1;
        check("t3_alu_a_issue", alu_a, 7);
        check("t3_grant", grant_id, 2);
        @(negedge clk);
        req_a[11:8] = 4'hC;
        #1;
        check("t3_alu_a_wait", alu_a, 7);
        check("t3_busy_wait", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t3_rst_busy", busy, 0);
        check("t3_rst_start", alu_start, 0);
        check("t3_rst_grant", grant_id, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t3_post_rst_idle", {busy, rsp_valid}, 0);
        end

        // Fairness: all four requesters valid for eight operations
        req_a     = {4'd4, 4'd3, 4'd2, 4'd1};
        req_b     = {4'd8, 4'd7, 4'd6, 4'd5};
        req_op    = 8'b11_10_01_00;
        alu_lat   = 1;
        req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 8; i++) begin
            int exp_g;
            exp_g     = i % 4;
            env_res   = 4'(i + 3);
            env_flags = 3'(i);
            wait_ready(10, cyc);
            check("fair_ready", req_ready, 32'(1) << exp_g);
            @(negedge clk);
            check("fair_grant", grant_id, exp_g);
            check("fair_alu_a", alu_a, exp_g + 1);
            check("fair_alu_op", alu_op, exp_g);
            wait_rsp(10, cyc);
            check("fair_rsp", rsp_valid, 32'(1) << exp_g);
            check("fair_result", rsp_result, i + 3);
            check("fair_flags", rsp_flags, i % 8);
        end
        @(negedge clk);
        req_valid = '0;

`ifdef ALU_ARB_TIMEOUT_EN
        // ALU never answers: error response after TIMEOUT_CYCLES WAIT cycles
        alu_en    = 1'b0;
        req_valid = 4'b0001;
        #1;
        check("to_ready", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(TIMEOUT_CYCLES + 10, cyc);
        check("to_latency", cyc, TIMEOUT_CYCLES + 1);
        check("to_rsp", rsp_valid, 4'b0001);
        check("to_err", rsp_err, 1);
        check("to_result", rsp_result, 0);
        check("to_flags", rsp_flags, 0);
        alu_en = 1'b1;
`else
        // Long ALU latency: the arbiter waits without any watchdog
        alu_lat   = 30;
        env_res   = 4'h5;
        env_flags = 3'b010;
        req_valid = 4'b0001;
        #1;
        check("long_ready", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(40, cyc);
        check("long_latency", cyc, 31);
        check("long_rsp", rsp_valid, 4'b0001);
        check("long_err", rsp_err, 0);
        check("long_result", rsp_result, 4'h5);
        check("long_flags", rsp_flags, 3'b010);
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares one secure 4-bit ALU instance (alu_clean_secure or alu_trojan_secure) among NUM_REQ requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU's operand and opcode inputs. It holds those inputs stable until the ALU signals completion, then returns the result and flags to the granted requester. It sits between requester logic and the ALU, so the ALU only sees new operands while idle.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8
ID_W, $clog2(NUM_REQ), width of grant index
TIMEOUT_CYCLES, 16, WAIT-state watchdog limit; used only with ALU_ARB_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester operation request
req_ready  out  NUM_REQ  per-requester accept; at most one bit set
req_a  in  NUM_REQ*4  packed operand A; requester i uses bits [4i+3:4i]
req_b  in  NUM_REQ*4  packed operand B, same packing as req_a
req_op  in  NUM_REQ*2  packed opcode; requester i uses bits [2i+1:2i]
rsp_valid  out  NUM_REQ  one-hot, single-cycle response strobe
rsp_result  out  4  result returned to the strobed requester
rsp_flags  out  3  {carry, zero, overflow}
rsp_err  out  1  response is a timeout, not an ALU result
alu_start  out  1  single-cycle launch pulse to ALU
alu_a  out  4  ALU operand A
alu_b  out  4  ALU operand B
alu_op  out  2  ALU opcode
alu_done  in  1  ALU completion pulse; result valid this cycle
alu_result  in  4  ALU result
alu_carry  in  1  ALU carry flag
alu_zero  in  1  ALU zero flag
alu_overflow  in  1  ALU overflow flag
grant_id  out  ID_W  index of the current or most recent grant
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst high, asynchronous):
  - state=IDLE; all outputs 0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-operation abandons the transaction; no rsp_valid is issued for it.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Winner g = first requester with req_valid set, searching from last_grant+1 and wrapping modulo NUM_REQ.
  - req_ready[g] is combinational and only asserted in IDLE.
  - On the handshake, register req_a/b/op slice g into alu_a/b/op, set grant_id=g, go to ISSUE.
  - No req_valid set: stay in IDLE; operand registers hold their previous values.
- ISSUE: alu_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - alu_a/b/op stay stable.
  - On alu_done, capture result and flags, go to RESP.
- RESP:
  - rsp_valid[g]=1 for one cycle; rsp_result/rsp_flags carry the captured values; rsp_err=0.
  - last_grant=g, go to IDLE.
  - rsp_result/flags/err hold until the next RESP.
- Latency: handshake at cycle T, alu_start at T+1, ALU latency L, alu_done at T+1+L, rsp_valid at T+2+L.
- Throughput: one operation per L+3 cycles.
- alu_done outside WAIT is ignored; no state change.
- alu_done in the same cycle as alu_start is not possible, since alu_start occurs in ISSUE; any such done is ignored.
- A requester dropping req_valid before its handshake loses nothing and gets no response.
- Fairness: with all requesters continuously valid, the grant order is 0,1,2,...,NUM_REQ-1,0,...
- A requester may re-request immediately; it still yields to any other pending requester.
- req_ready and rsp_valid are never asserted in the same cycle.

Optional Feature:
ALU_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no alu_done: go to RESP with rsp_err=1, rsp_result=0, rsp_flags=0.
  - alu_done in the same cycle as the timeout counts as success.
  - Late alu_done pulses are ignored.
- Undefined: rsp_err is tied 0 and WAIT waits indefinitely.

Test Plan:
- Reset, then req_valid=4'b0001, A=3, B=5, op=ADD, ALU L=2 -> req_ready[0] at T, alu_start at T+1, rsp_valid=4'b0001 at T+4 with result=8 and flags=000.
- All four requesters held valid for 8 operations -> grant_id sequence 0,1,2,3,0,1,2,3; no requester granted twice in a row.
- Operands changed on req_a during WAIT -> alu_a stays at the value latched at the handshake.
- rst pulsed during WAIT -> busy=0 and alu_start=0 immediately; no rsp_valid; next grant goes to requester 0.
- Stray alu_done injected in IDLE -> no state change, no rsp_valid.
- With ALU_ARB_TIMEOUT_EN and alu_done never asserted -> rsp_valid after TIMEOUT_CYCLES WAIT cycles with rsp_err=1, result=0, flags=000.
